// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad reader: scans active-low rows, debounces whole frames and
// hands each accepted key to the consumer through a one-entry valid/ready register.
module keypad_scanner #(
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row,
  input  logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       key_down,
  output logic       overflow
);

  localparam int                DIV_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [3:0]        DEB_LAST = 4'(DEBOUNCE - 1);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, RELEASE_CHK} state_t;

  logic [3:0]       col_meta, col_sync;
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       row_idx;
  logic [11:0]      frame_lo;
  logic             sample_en, frame_end;
  logic [15:0]      frame_img;
  logic [4:0]       ones;
  logic [3:0]       hit;
  logic             is_none, is_single;
  state_t           state;
  logic [3:0]       cand;
  logic [3:0]       cnt;
  logic             accept;

  // NOTE: every register below uses non-blocking assignment so all flops
  // update together on the edge and simulation matches the synthesized netlist.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta <= 4'hF;
      col_sync <= 4'hF;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
    end
  end

  assign sample_en = (div_cnt == DIV_LAST);
  assign frame_end = sample_en && (row_idx == 2'd3);
  // Rows 0-2 come from the stored image; row 3 is the sample being taken now.
  assign frame_img = {~col_sync, frame_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      row_idx  <= 2'd0;
      row      <= 4'b1110;
      frame_lo <= '0;
    end else if (sample_en) begin
      div_cnt <= '0;
      row_idx <= row_idx + 2'd1;
      row     <= ~(4'b0001 << (row_idx + 2'd1));
      case (row_idx)
        2'd0:    frame_lo[3:0]  <= ~col_sync;
        2'd1:    frame_lo[7:4]  <= ~col_sync;
        2'd2:    frame_lo[11:8] <= ~col_sync;
        default: ;
      endcase
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  // NOTE: outputs of this combinational block get defaults first so no path
  // leaves them unassigned, which would otherwise infer latches.
  always_comb begin
    ones = '0;
    hit  = '0;
    for (int i = 0; i < 16; i++) begin
      if (frame_img[i]) begin
        ones = ones + 5'd1;
        hit  = 4'(i);
      end
    end
    is_none   = (ones == 5'd0);
    is_single = (ones == 5'd1);
  end

  assign accept = frame_end && is_single &&
                  ((state == IDLE && DEBOUNCE == 1) ||
                   (state == PRESS_CHK && hit == cand && cnt == DEB_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_down  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (key_valid && key_ready)
        key_valid <= 1'b0;

      // A simultaneous consume frees the slot for the incoming key.
      if (accept) begin
        if (!key_valid || key_ready) begin
          key_code  <= hit;
          key_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end

      if (frame_end) begin
        case (state)
          IDLE: begin
            if (is_single) begin
              cand <= hit;
              cnt  <= 4'd1;
              if (accept) begin
                state    <= HELD;
                key_down <= 1'b1;
              end else begin
                state <= PRESS_CHK;
              end
            end
          end
          PRESS_CHK: begin
            if (is_single && hit == cand) begin
              cnt <= cnt + 4'd1;
              if (accept) begin
                state    <= HELD;
                key_down <= 1'b1;
              end
            end else if (is_single) begin
              cand <= hit;
              cnt  <= 4'd1;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
          HELD: begin
            if (is_none) begin
              cnt <= 4'd1;
              if (DEBOUNCE == 1) begin
                state    <= IDLE;
                key_down <= 1'b0;
              end else begin
                state <= RELEASE_CHK;
              end
            end
          end
          RELEASE_CHK: begin
            if (is_none) begin
              cnt <= cnt + 4'd1;
              if (cnt == DEB_LAST) begin
                state    <= IDLE;
                key_down <= 1'b0;
              end
            end else begin
              state <= HELD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
